// File: rtl/keypad_pkg.sv
// Shared constants for the 4x4 keypad scanner: FSM encoding,
// active-low row patterns, repeat period and small decode helpers.
package keypad_pkg;

    localparam logic [1:0] ST_SCAN     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_HELD     = 2'd2;

    localparam logic [3:0] ROW0 = 4'b1110;
    localparam logic [3:0] ROW1 = 4'b1101;
    localparam logic [3:0] ROW2 = 4'b1011;
    localparam logic [3:0] ROW3 = 4'b0111;

    localparam int REPEAT_SCANS = 64;

    // Row pattern -> row index (0 for ROW0 .. 3 for ROW3).
    function automatic logic [1:0] row_index(input logic [3:0] row);
        logic [1:0] idx;
        case (row)
            ROW1:    idx = 2'd1;
            ROW2:    idx = 2'd2;
            ROW3:    idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // Lowest active-low column index; only meaningful when one is low.
    function automatic logic [1:0] col_index(input logic [3:0] col);
        logic [1:0] idx;
        if (!col[0])      idx = 2'd0;
        else if (!col[1]) idx = 2'd1;
        else if (!col[2]) idx = 2'd2;
        else              idx = 2'd3;
        return idx;
    endfunction

    // True when exactly one active-low column is asserted.
    function automatic logic single_low(input logic [3:0] col);
        return $onehot(~col);
    endfunction

    // Next row in the scan rotation 1110->1101->1011->0111->1110.
    function automatic logic [3:0] next_row(input logic [3:0] row);
        return {row[2:0], row[3]};
    endfunction

endpackage

// File: rtl/kp_tick_gen.sv
// Scan-rate divider: counts 0..SCAN_DIV-1 and flags the last count
// as a one-cycle tick that paces every keypad decision.
module kp_tick_gen #(
    parameter int SCAN_DIV = 10000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    // Free-running wrap counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with debounce and a 4-digit entry register.
// Optional auto-repeat while held: define KEYPAD_AUTOREPEAT_EN.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 10000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  col_sense,
    input  logic        clear,
    output logic [3:0]  row_drive,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic [15:0] entry_value
);

    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE_SCANS);
    localparam logic [CW-1:0] DB_ONE = CW'(1);

    logic [3:0]    col_meta;
    logic [3:0]    col_sync;
    logic          tick;
    logic [1:0]    state;
    logic [1:0]    lat_row;
    logic [1:0]    lat_col;
    logic [CW-1:0] db_cnt;
    logic [CW-1:0] rel_cnt;
    logic          one_low;
    logic          all_high;
    logic          only_lat;
    logic [3:0]    lat_pat;
    logic [CW-1:0] db_inc;
    logic [CW-1:0] rel_inc;
    logic          accept;
    logic [3:0]    acc_code;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_SCANS);
    localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_SCANS - 1);
    logic [RW-1:0] rpt_cnt;
`endif

    kp_tick_gen #(
        .SCAN_DIV (SCAN_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    // Two-flop synchronizer for the asynchronous column inputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_meta <= 4'hF;
            col_sync <= 4'hF;
        end else begin
            col_meta <= col_sense;
            col_sync <= col_meta;
        end
    end

    assign one_low  = single_low(col_sync);
    assign all_high = (col_sync == 4'hF);
    assign lat_pat  = ~(4'b0001 << lat_col);
    assign only_lat = (col_sync == lat_pat);
    assign db_inc   = db_cnt + DB_ONE;
    assign rel_inc  = rel_cnt + DB_ONE;

    // Decide on this tick whether a key is accepted and with which code.
    always_comb begin
        accept   = 1'b0;
        acc_code = {lat_row, lat_col};
        case (state)
            ST_SCAN: begin
                acc_code = {row_index(row_drive), col_index(col_sync)};
                accept   = tick && one_low && (DEBOUNCE_SCANS == 1);
            end
            ST_DEBOUNCE: begin
                accept = tick && only_lat && (db_inc == DB_MAX);
            end
            ST_HELD: begin
`ifdef KEYPAD_AUTOREPEAT_EN
                accept = tick && !all_high && (rpt_cnt == RPT_LAST);
`else
                accept = 1'b0;
`endif
            end
            default: begin
                accept = 1'b0;
            end
        endcase
    end

    // Scan/debounce/held state machine; it only moves on tick cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_SCAN;
            row_drive <= ROW0;
            lat_row   <= 2'd0;
            lat_col   <= 2'd0;
            db_cnt    <= '0;
            rel_cnt   <= '0;
        end else if (tick) begin
            case (state)
                ST_SCAN: begin
                    if (one_low) begin
                        lat_row <= row_index(row_drive);
                        lat_col <= col_index(col_sync);
                        db_cnt  <= DB_ONE;
                        rel_cnt <= '0;
                        if (DEBOUNCE_SCANS == 1) begin
                            state <= ST_HELD;
                        end else begin
                            state <= ST_DEBOUNCE;
                        end
                    end else begin
                        row_drive <= next_row(row_drive);
                    end
                end
                ST_DEBOUNCE: begin
                    if (only_lat) begin
                        db_cnt <= db_inc;
                        if (db_inc == DB_MAX) begin
                            state   <= ST_HELD;
                            rel_cnt <= '0;
                        end
                    end else begin
                        state     <= ST_SCAN;
                        db_cnt    <= '0;
                        row_drive <= next_row(row_drive);
                    end
                end
                ST_HELD: begin
                    if (all_high) begin
                        if (rel_inc == DB_MAX) begin
                            state   <= ST_SCAN;
                            rel_cnt <= '0;
                            db_cnt  <= '0;
                        end else begin
                            rel_cnt <= rel_inc;
                        end
                    end else begin
                        rel_cnt <= '0;
                    end
                end
                default: begin
                    state <= ST_SCAN;
                end
            endcase
        end
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    // Repeat period counts only ticks where the key is still down.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rpt_cnt <= '0;
        end else if (tick) begin
            if (state != ST_HELD) begin
                rpt_cnt <= '0;
            end else if (!all_high) begin
                if (rpt_cnt == RPT_LAST) begin
                    rpt_cnt <= '0;
                end else begin
                    rpt_cnt <= rpt_cnt + RW'(1);
                end
            end
        end
    end
`endif

    // Key pulse, last code and entry shift register; clear wins the shift.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_valid   <= 1'b0;
            key_code    <= 4'h0;
            entry_value <= 16'h0000;
        end else begin
            key_valid <= accept;
            if (accept) begin
                key_code <= acc_code;
            end
            if (clear) begin
                entry_value <= 16'h0000;
            end else if (accept) begin
                entry_value <= {entry_value[11:0], acc_code};
            end
        end
    end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 10000, clk cycles per scan tick (row dwell), minimum 2.
REQ-002 SHALL have parameter DEBOUNCE_SCANS, default 4, consecutive ticks needed to accept a press or a release, minimum 1.
REQ-003 SHALL have port clk  input  1  system clock.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port col_sense  input  4  keypad columns, active-low, asynchronous to clk.
REQ-006 SHALL have port clear  input  1  synchronous clear of entry_value.
REQ-007 SHALL have port row_drive  output  4  keypad rows, active-low one-hot.
REQ-008 SHALL have port key_valid  output  1  one-cycle pulse per accepted key.
REQ-009 SHALL have port key_code  output  4  code of last accepted key.
REQ-010 SHALL have port entry_value  output  16  last four accepted codes, newest in [3:0].

Function
REQ-011 SHALL pass col_sense through a 2-flop synchronizer; all decisions SHALL use the synchronized value.
REQ-012 SHALL use a tick counter running 0..SCAN_DIV-1 that wraps, with tick high for one cycle when the count equals SCAN_DIV-1.
REQ-013 SHALL have an FSM with states SCAN, DEBOUNCE and HELD; all transitions SHALL occur only on tick cycles.
REQ-014 SCAN: on each tick, row_drive SHALL rotate 1110->1101->1011->0111->1110, unless exactly one synchronized column is low.
REQ-015 SCAN: if exactly one column is low on a tick, the FSM SHALL latch row index r (0 for 1110 ... 3 for 0111) and column index c (0 for col_sense[0] low), freeze row_drive, set debounce count to 1, and go to DEBOUNCE.
REQ-016 SCAN: two or more columns low SHALL be treated as no key; the row keeps rotating.
REQ-017 DEBOUNCE: on each tick, if only the latched column is low, the count SHALL increment; otherwise the FSM SHALL return to SCAN with the count cleared and rotation resumed.
REQ-018 DEBOUNCE: when the count reaches DEBOUNCE_SCANS, the block SHALL go to HELD and, in the next clk cycle, pulse key_valid for exactly one cycle with key_code = 4*r + c.
REQ-019 With DEBOUNCE_SCANS=1, acceptance SHALL occur on the same tick that detects the press.
REQ-020 On each key_valid, entry_value SHALL become {entry_value[11:0], key_code}, so the oldest nibble is discarded.
REQ-021 HELD: row_drive SHALL stay frozen; on each tick, all columns high SHALL increment the release count and any column low SHALL clear it.
REQ-022 HELD: when the release count reaches DEBOUNCE_SCANS, the FSM SHALL return to SCAN, resuming rotation from the frozen row.
REQ-023 clear SHALL set entry_value to 0 in the cycle it is sampled; clear takes priority over the key_valid shift in the same cycle, and key_valid/key_code SHALL still update.
REQ-024 key_code SHALL hold its value between accepted keys.

Reset
REQ-025 On reset, the block SHALL set row_drive=4'b1110, key_valid=0, key_code=0, entry_value=0, FSM=SCAN, and clear the tick counter, debounce/release counts and synchronizer flops (to 1).
REQ-026 Reset asserted mid-DEBOUNCE or mid-HELD SHALL abort the key with no key_valid pulse.

Configuration
REQ-027 With macro KEYPAD_AUTOREPEAT_EN defined, a key held in HELD for REPEAT_SCANS consecutive ticks (not counting ticks with all columns high) SHALL re-pulse key_valid with the same key_code and shift entry_value, then restart that count.
REQ-028 Without KEYPAD_AUTOREPEAT_EN, the block SHALL produce exactly one key_valid per press, and no repeat counter SHALL be present.

Structure
REQ-029 Package keypad_pkg SHALL hold the FSM state encoding, the row one-hot constants (ROW0=4'b1110 .. ROW3=4'b0111) and REPEAT_SCANS=64.
REQ-030 Sub-module kp_tick_gen (parameter SCAN_DIV; ports clk, reset, tick) SHALL implement the tick counter; all other logic SHALL stay in keypad_scanner.

Verification (SCAN_DIV=4, DEBOUNCE_SCANS=2 unless noted)
REQ-031 Release reset -> row_drive=1110, key_valid=0, entry_value=0x0000; row_drive advances one step every 4 cycles.
REQ-032 Hold col_sense=1101 whenever row_drive=1011, then release -> single key_valid, key_code=0x9, entry_value=0x0009, FSM back in SCAN after 2 idle ticks.
REQ-033 Press codes 1,2,3,4, then 5 -> entry_value=0x1234, then 0x2345; assert clear together with a sixth key -> entry_value=0x0000 and key_valid pulses.
REQ-034 Press lasting 1 tick only, or col_sense=1100 -> no key_valid, and row rotation continues.
REQ-035 Assert reset during DEBOUNCE -> no key_valid, row_drive=1110, entry_value unchanged value 0.
REQ-036 Hold key 0xF for 200 ticks: with KEYPAD_AUTOREPEAT_EN -> 4 key_valid pulses (at 0, 64, 128, 192 ticks after acceptance), entry_value=0xFFFF; without it -> 1 pulse, entry_value=0x000F.
